// File: rtl/bf_spi_pkg.sv
// Shared SPI framing constants and types for the beamformer calc units and the frame arbiter.
package bf_spi_pkg;
  localparam int         FRAME_BYTES_DEF = 5;
  localparam logic [7:0] HEADER_BYTE_DEF = 8'h28;
  localparam int         BYTE_IDX_W      = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Wide enough to hold FRAME_BYTES itself, where the index saturates on overlong frames.
  typedef logic [BYTE_IDX_W-1:0] byte_idx_t;
endpackage

// File: rtl/bf_rr_picker.sv
// Combinational round-robin picker: first asserted request searching upward from rr_ptr+1, wrapping.
module bf_rr_picker #(
  parameter int N = 8
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] rr_ptr,
  output logic                 any,
  output logic [$clog2(N)-1:0] idx
);
  localparam int IW = $clog2(N);

  logic [IW-1:0] cand;

  // Walk from farthest to nearest so the nearest requester is the last one written.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = N; k >= 1; k--) begin
      cand = IW'((int'(rr_ptr) + k) % N);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end
endmodule

// File: rtl/bf_spi_frame_arbiter.sv
// Frame-atomic round-robin arbiter merging per-unit SPI byte streams onto one SPI master channel,
// with header/length checks, a mid-frame stall watchdog and a completed-frame counter.
module bf_spi_frame_arbiter
  import bf_spi_pkg::*;
#(
  parameter int         NUM_UNITS   = 8,
  parameter int         FRAME_BYTES = FRAME_BYTES_DEF,
  parameter logic [7:0] HEADER_BYTE = HEADER_BYTE_DEF,
  parameter int         TIMEOUT     = 255,
  parameter int         CNT_W       = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_UNITS*8-1:0]       s_wdata,
  input  logic [NUM_UNITS-1:0]         s_wvalid,
  input  logic [NUM_UNITS-1:0]         s_wlast,
  output logic [NUM_UNITS-1:0]         s_wready,
  output logic [7:0]                   m_wdata,
  output logic                         m_wvalid,
  output logic                         m_wlast,
  input  logic                         m_wready,
  output logic                         m_abort,
  output logic [$clog2(NUM_UNITS)-1:0] grant_id,
  output logic                         busy,
  output logic [CNT_W-1:0]             frame_cnt,
  input  logic                         clr_cnt,
  output logic                         err_len,
  output logic                         err_hdr,
  output logic                         err_timeout
);
  localparam int IW   = $clog2(NUM_UNITS);
  localparam int TO_W = $clog2(TIMEOUT + 1);

  arb_state_e     state_q, state_d;
  logic [IW-1:0]  grant_q, grant_d, rr_q, rr_d, pick_idx;
  logic           pick_any;
  byte_idx_t      bidx_q, bidx_d;
  logic [TO_W-1:0] idle_q, idle_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           err_len_q, err_len_d, err_hdr_q, err_hdr_d, abort_q, abort_d;
  logic [7:0]     g_data;
  logic           g_valid, g_last, hs;

  bf_rr_picker #(.N(NUM_UNITS)) u_picker (
    .req    (s_wvalid),
    .rr_ptr (rr_q),
    .any    (pick_any),
    .idx    (pick_idx)
  );

  // Handshake: a byte moves on a cycle where m_wvalid & m_wready; the granted unit sees
  // s_wready = m_wready, so source and sink agree on every transfer with zero latency.
  assign g_data  = s_wdata[{grant_q, 3'b000} +: 8];
  assign g_valid = s_wvalid[grant_q];
  assign g_last  = s_wlast[grant_q];

  assign busy     = (state_q == GRANT);
  assign m_wdata  = busy ? g_data : 8'h00;
  assign m_wvalid = busy & g_valid;
  assign m_wlast  = busy & g_last;
  assign hs       = m_wvalid & m_wready;

  always_comb begin
    s_wready = '0;
    if (busy) s_wready[grant_q] = m_wready;
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    bidx_d    = bidx_q;
    idle_d    = idle_q;
    cnt_d     = cnt_q;
    err_len_d = 1'b0;
    err_hdr_d = 1'b0;
    abort_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          grant_d = pick_idx;
          rr_d    = pick_idx;
          bidx_d  = '0;
          idle_d  = '0;
        end
      end
      GRANT: begin
        // Backpressure keeps valid high, so only a silent source can trip the watchdog.
        if (g_valid) begin
          idle_d = '0;
        end else if (idle_q == TO_W'(TIMEOUT - 1)) begin
          idle_d  = '0;
          abort_d = 1'b1;
          state_d = IDLE;
        end else begin
          idle_d = idle_q + 1'b1;
        end
        if (hs) begin
          if (bidx_q == '0 && g_data != HEADER_BYTE) err_hdr_d = 1'b1;
          if (bidx_q != byte_idx_t'(FRAME_BYTES)) bidx_d = bidx_q + 1'b1;
          if (g_last) begin
            state_d = IDLE;
            cnt_d   = cnt_q + 1'b1;
            if (bidx_q != byte_idx_t'(FRAME_BYTES - 1)) err_len_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (clr_cnt) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_q      <= IW'(NUM_UNITS - 1);
      bidx_q    <= '0;
      idle_q    <= '0;
      cnt_q     <= '0;
      err_len_q <= 1'b0;
      err_hdr_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      bidx_q    <= bidx_d;
      idle_q    <= idle_d;
      cnt_q     <= cnt_d;
      err_len_q <= err_len_d;
      err_hdr_q <= err_hdr_d;
      abort_q   <= abort_d;
    end
  end

  assign grant_id    = grant_q;
  assign frame_cnt   = cnt_q;
  assign err_len     = err_len_q;
  assign err_hdr     = err_hdr_q;
  assign m_abort     = abort_q;
  assign err_timeout = abort_q;
endmodule
